// File: rtl/two_pulses_pkg.sv
// Shared types and constants for the two-pulse input conditioning stage.
package two_pulses_pkg;

  // Per-channel debounce FSM states.
  typedef enum logic [1:0] {
    StLow     = 2'd0,
    StRiseChk = 2'd1,
    StHigh    = 2'd2,
    StFallChk = 2'd3
  } deb_state_e;

  // Depth of the metastability synchronizer.
  localparam int unsigned SYNC_STAGES = 2;

  // Width of the optional pulse statistics counters.
  localparam int unsigned STATS_W = 8;

endpackage

// File: rtl/pulse_debounce.sv
// One input channel: 2-flop synchronizer, debounce FSM with qualification
// counter, and a registered single-cycle pulse on each accepted rising edge.
module pulse_debounce
  import two_pulses_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic pulse_o
);

  localparam int unsigned     CntW         = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax       = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CntW-1:0] CntOne       = CntW'(1);
  // With a single-sample window, the check states are skipped entirely.
  localparam bit              SingleSample = (DEBOUNCE_CYCLES == 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  deb_state_e             state_q;
  logic [CntW-1:0]        cnt_q;
  logic                   pulse_q;

  // Shift the raw level through the synchronizer chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Debounce FSM; the pulse is registered and fires only on entry to StHigh
  // from the low side, so a bounce back from StFallChk never pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StLow;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      unique case (state_q)
        StLow: begin
          if (s) begin
            if (SingleSample) begin
              state_q <= StHigh;
              pulse_q <= 1'b1;
            end else begin
              state_q <= StRiseChk;
              cnt_q   <= CntOne;
            end
          end
        end
        StRiseChk: begin
          if (!s) begin
            state_q <= StLow;
            cnt_q   <= '0;
          end else if (cnt_q == CntMax) begin
            state_q <= StHigh;
            cnt_q   <= '0;
            pulse_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StHigh: begin
          if (!s) begin
            if (SingleSample) begin
              state_q <= StLow;
            end else begin
              state_q <= StFallChk;
              cnt_q   <= CntOne;
            end
          end
        end
        StFallChk: begin
          if (s) begin
            state_q <= StHigh;
            cnt_q   <= '0;
          end else if (cnt_q == CntMax) begin
            state_q <= StLow;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        default: begin
          state_q <= StLow;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/two_pulses_cond.sv
// Input conditioning for the two-pulse detector: two independent debounced
// channels (x, y), each emitting one registered pulse per qualified rise.
// Optional saturating pulse counters are built when TWO_PULSES_STATS_EN is
// defined; the pulse outputs behave identically in both builds.
module two_pulses_cond
  import two_pulses_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               x_raw_i,
  input  logic               y_raw_i,
`ifdef TWO_PULSES_STATS_EN
  input  logic               stats_clr_i,
  output logic [STATS_W-1:0] x_cnt_o,
  output logic [STATS_W-1:0] y_cnt_o,
`endif
  output logic               x_o,
  output logic               y_o
);

  pulse_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_x_debounce (
    .clk    (clk),
    .reset  (reset),
    .raw_i  (x_raw_i),
    .pulse_o(x_o)
  );

  pulse_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_y_debounce (
    .clk    (clk),
    .reset  (reset),
    .raw_i  (y_raw_i),
    .pulse_o(y_o)
  );

`ifdef TWO_PULSES_STATS_EN
  localparam logic [STATS_W-1:0] CntSat = '1;
  localparam logic [STATS_W-1:0] CntInc = STATS_W'(1);

  logic [STATS_W-1:0] x_cnt_q;
  logic [STATS_W-1:0] y_cnt_q;

  // Saturating pulse counters; a clear takes precedence over an increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_cnt_q <= '0;
      y_cnt_q <= '0;
    end else if (stats_clr_i) begin
      x_cnt_q <= '0;
      y_cnt_q <= '0;
    end else begin
      if (x_o && (x_cnt_q != CntSat)) x_cnt_q <= x_cnt_q + CntInc;
      if (y_o && (y_cnt_q != CntSat)) y_cnt_q <= y_cnt_q + CntInc;
    end
  end

  assign x_cnt_o = x_cnt_q;
  assign y_cnt_o = y_cnt_q;
`endif

endmodule
